ha_serial_sched: RTL and testbench
==================================

Name: ha_serial_sched

Overview:
Bit-serial add scheduler built around a shared half-adder datapath cell. Two requesters submit WIDTH-bit operand pairs. A round-robin arbiter grants one requester at a time. The block sequences the operands LSB-first through two half-adder cells plus a carry register, WIDTH cycles per operation. It returns the sum, carry-out and requester ID on a valid/ready result port.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..16.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset; one clock domain.
a_valid  input  1  requester A has an operand pair.
a_x  input  WIDTH  requester A operand X.
a_y  input  WIDTH  requester A operand Y.
a_ready  output  1  requester A pair accepted this cycle when a_valid is also high.
b_valid  input  1  requester B has an operand pair.
b_x  input  WIDTH  requester B operand X.
b_y  input  WIDTH  requester B operand Y.
b_ready  output  1  requester B accept strobe.
busy  output  1  high in RUN or DONE.
res_valid  output  1  result available.
res_sum  output  WIDTH  X+Y modulo 2^WIDTH.
res_cout  output  1  carry out of the MSB.
res_id  output  1  0 = requester A, 1 = requester B.
res_ready  input  1  consumer accepts the result.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Values at reset: res_valid=0, res_sum=0, res_cout=0, res_id=0, busy=0, carry=0, bit counter=0, last_grant=B (so A wins first).
- Arbitration runs only in IDLE and is combinational.
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
- a_ready = IDLE & grant==A; b_ready = IDLE & grant==B. At most one ready is high in any cycle.
- Ready may depend combinationally on valid. Valid must never depend on ready.
- Accept edge (IDLE, granted valid high):
  - Latch x and y into shift registers.
  - Latch res_id and update last_grant.
  - Clear carry and counter.
  - Go to RUN.
- RUN, each cycle:
  - Half-adder 1 takes x[0] and y[0], giving s1 and c1.
  - Half-adder 2 takes s1 and carry, giving the sum bit and c2.
  - next carry = c1 | c2.
  - The sum bit shifts into the MSB of the sum shift register; x and y shift right.
  - The counter increments.
- When the counter reaches WIDTH-1, the same edge moves the state to DONE and registers res_cout = next carry.
- DONE: res_valid=1. res_sum, res_cout and res_id stay stable until res_valid & res_ready.
  - On that handshake the state returns to IDLE and res_valid drops the next cycle.
- Latency: with accept at edge T, res_valid goes high after edge T+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles, since IDLE costs one cycle after the DONE handshake.
  - No new request is accepted in the same cycle as the result handshake.
- While res_ready is held low, the block stays in DONE indefinitely. Both ready outputs stay low and requesters keep their valid asserted.
- A requester deasserting valid while not granted is legal and leaves the arbiter unaffected.
- If last_grant=A and only A is valid, A is granted again; there is no idle-slot reservation.
- Overflow: the sum wraps modulo 2^WIDTH and the overflow is reported solely via res_cout.
- Reset mid-operation: asserting rst at any time returns immediately to the reset values.
  - Any in-flight operation is discarded with no result emitted.
  - The first accept after reset grants A if both are valid.
- Operand inputs are sampled only on the accept edge. Changes at other times are ignored.

Decomposition:
- Package ha_sched_pkg holds:
  - state enum: IDLE, RUN, DONE;
  - requester ID constants: REQ_A=0, REQ_B=1;
  - localparam CNT_W = $clog2(WIDTH).
- Sub-module ha_cell is a pure combinational half adder: inputs a and b, outputs s = a^b and c = a&b. It is instantiated twice.
- The top level holds the arbiter, FSM, counter and shift registers.

Test Plan:
1. After reset, A sends x=0x3C, y=0x0F while B is idle: a_ready is high for 1 cycle. After 8 cycles res_valid=1 with res_sum=0x4B, res_cout=0, res_id=0.
2. A sends x=0xFF, y=0x01: res_sum=0x00, res_cout=1. Then B sends x=0xFF, y=0xFF: res_sum=0xFE, res_cout=1, res_id=1.
3. A and B both hold valid continuously with distinct operands, res_ready=1: grants alternate A,B,A,B over 4 operations, each result is correct, and the issue interval is exactly 10 cycles.
4. With a result pending, res_ready is held low for 5 cycles: res_valid and the result fields stay constant, and a_ready/b_ready stay 0 despite both valid. Raising res_ready gives a handshake, then one IDLE cycle, then the next accept.
5. rst is pulsed for 1 cycle at RUN counter=3 of an A operation: all outputs go to reset values immediately and no result is emitted. Then x=0x80, y=0x80 from B gives res_sum=0x00, res_cout=1, res_id=1.
6. A 200-operation random stress against a reference model (x+y, requester order checked against round-robin), with random res_ready backpressure: zero mismatches, and never both ready high in the same cycle.

Source files
------------

// File: rtl/ha_sched_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
package ha_sched_pkg;

   // Scheduler control states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Requester identifiers as carried on res_id and held in last_grant
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   // Default operand width and the matching bit-counter width
   localparam int DEFAULT_WIDTH = 8;

   // Counter width needed to count 0..w-1
   function automatic int cntWidth(input int w);
      return $clog2(w);
   endfunction

   localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/ha_cell.sv
// Single-bit half adder used as the shared serial datapath cell.
module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Sum is the XOR of the inputs and carry is their AND
   assign s = a ^ b;
   assign c = a & b;

endmodule

// File: rtl/ha_serial_sched.sv
// Two-requester round-robin scheduler that adds operand pairs LSB-first
// through two half-adder cells and a carry register, WIDTH cycles per add.
module ha_serial_sched
   import ha_sched_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_x,
   input  logic [WIDTH-1:0] a_y,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_x,
   input  logic [WIDTH-1:0] b_y,
   output logic             b_ready,
   output logic             busy,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_id,
   input  logic             res_ready
);

   localparam int                  CNT_BITS = cntWidth(WIDTH);
   localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    xShift_q, xShift_d;
   logic [WIDTH-1:0]    yShift_q, yShift_d;
   logic [WIDTH-1:0]    sumShift_q, sumShift_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic                resCout_q, resCout_d;
   logic                resId_q, resId_d;
   logic                lastGrant_q, lastGrant_d;

   logic grantA, grantB;
   logic s1, c1, sumBit, c2, carryNext;

   ha_cell uHa1 (
      .a (xShift_q[0]),
      .b (yShift_q[0]),
      .s (s1),
      .c (c1)
   );

   ha_cell uHa2 (
      .a (s1),
      .b (carry_q),
      .s (sumBit),
      .c (c2)
   );

   assign carryNext = c1 | c2;

   // Round-robin arbiter, active only in IDLE; on a tie the requester that did not win last time is granted
   always_comb begin
      grantA = 1'b0;
      grantB = 1'b0;
      if (state_q == IDLE) begin
         if (a_valid && b_valid) begin
            grantA = (lastGrant_q == REQ_B);
            grantB = (lastGrant_q == REQ_A);
         end else begin
            grantA = a_valid;
            grantB = b_valid;
         end
      end
   end

   assign a_ready   = grantA;
   assign b_ready   = grantB;
   assign busy      = (state_q != IDLE);
   assign res_valid = (state_q == DONE);
   assign res_sum   = sumShift_q;
   assign res_cout  = resCout_q;
   assign res_id    = resId_q;

   // Next-state and datapath update: load on accept, shift one bit per RUN cycle, hold in DONE until consumed
   always_comb begin
      state_d     = state_q;
      xShift_d    = xShift_q;
      yShift_d    = yShift_q;
      sumShift_d  = sumShift_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      resCout_d   = resCout_q;
      resId_d     = resId_q;
      lastGrant_d = lastGrant_q;
      unique case (state_q)
         IDLE: begin
            if (grantA || grantB) begin
               xShift_d    = grantB ? b_x : a_x;
               yShift_d    = grantB ? b_y : a_y;
               resId_d     = grantB ? REQ_B : REQ_A;
               lastGrant_d = grantB ? REQ_B : REQ_A;
               carry_d     = 1'b0;
               cnt_d       = '0;
               state_d     = RUN;
            end
         end
         RUN: begin
            xShift_d   = xShift_q >> 1;
            yShift_d   = yShift_q >> 1;
            sumShift_d = {sumBit, sumShift_q[WIDTH-1:1]};
            carry_d    = carryNext;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               resCout_d = carryNext;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and biases the first tie toward A
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         xShift_q    <= '0;
         yShift_q    <= '0;
         sumShift_q  <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         resCout_q   <= 1'b0;
         resId_q     <= REQ_A;
         lastGrant_q <= REQ_B;
      end else begin
         state_q     <= state_d;
         xShift_q    <= xShift_d;
         yShift_q    <= yShift_d;
         sumShift_q  <= sumShift_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         resCout_q   <= resCout_d;
         resId_q     <= resId_d;
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: tb/tb_ha_serial_sched.sv
// Directed-vector and random-stress bench for the serial add scheduler.
module tb_ha_serial_sched;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             a_valid;
   logic [WIDTH-1:0] a_x;
   logic [WIDTH-1:0] a_y;
   logic             a_ready;
   logic             b_valid;
   logic [WIDTH-1:0] b_x;
   logic [WIDTH-1:0] b_y;
   logic             b_ready;
   logic             busy;
   logic             res_valid;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_id;
   logic             res_ready;

   int errCount   = 0;
   int checkCount = 0;
   int cyc        = 0;

   typedef struct {
      logic             aV;
      logic [WIDTH-1:0] aX;
      logic [WIDTH-1:0] aY;
      logic             bV;
      logic [WIDTH-1:0] bX;
      logic [WIDTH-1:0] bY;
      logic [WIDTH-1:0] expSum;
      logic             expCout;
      logic             expId;
   } vec_t;

   vec_t vecs[8];

   logic seenA, seenB;
   bit   ok;
   int   lat;
   int   prevCyc;
   logic modelLast;
   logic expId;
   logic [WIDTH:0] full;
   logic sawResult;
   logic [1:0] sel;

   ha_serial_sched #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_valid   (a_valid),
      .a_x       (a_x),
      .a_y       (a_y),
      .a_ready   (a_ready),
      .b_valid   (b_valid),
      .b_x       (b_x),
      .b_y       (b_y),
      .b_ready   (b_ready),
      .busy      (busy),
      .res_valid (res_valid),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_id    (res_id),
      .res_ready (res_ready)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure issue intervals
   always @(posedge clk) cyc <= cyc + 1;

   // Overall time bound so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time bound");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic reportTimeout(input string name);
      checkCount++;
      errCount++;
      $display("[TB] FAIL %s: bound expired without the expected event at %0t", name, $time);
   endtask

   // Advance to 2 ns after the next rising edge; readies must never both be high
   task automatic nextCycle();
      @(posedge clk);
      #2;
      checkOutput("readyMutex", 32'(a_ready & b_ready), 32'd0);
   endtask

   task automatic waitAccept(output logic gotA, output logic gotB, output bit found);
      gotA  = 1'b0;
      gotB  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (a_ready || b_ready) begin
            gotA  = a_ready;
            gotB  = b_ready;
            found = 1'b1;
            break;
         end
         nextCycle();
      end
      if (!found) reportTimeout("acceptWait");
   endtask

   task automatic waitResult(output int cycles, output bit found);
      cycles = 0;
      found  = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (res_valid) begin
            found = 1'b1;
            break;
         end
         nextCycle();
         cycles++;
      end
      if (!found) reportTimeout("resultWait");
   endtask

   task automatic doReset();
      rst       = 1'b1;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      res_ready = 1'b0;
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   // One complete transaction: present, check grant, check latency and result, drain
   task automatic applyStimulus(input vec_t v);
      logic gA, gB;
      bit   fnd;
      int   l;
      a_valid   = v.aV;
      a_x       = v.aX;
      a_y       = v.aY;
      b_valid   = v.bV;
      b_x       = v.bX;
      b_y       = v.bY;
      res_ready = 1'b1;
      waitAccept(gA, gB, fnd);
      if (fnd) begin
         checkOutput("vecGrantA", 32'(gA), 32'(!v.expId));
         checkOutput("vecGrantB", 32'(gB), 32'(v.expId));
         nextCycle();
         checkOutput("vecReadyInRun", 32'({a_ready, b_ready}), 32'd0);
         checkOutput("vecBusy", 32'(busy), 32'd1);
         a_valid = 1'b0;
         b_valid = 1'b0;
         waitResult(l, fnd);
         if (fnd) begin
            checkOutput("vecLatency", 32'(l), 32'(WIDTH));
            checkOutput("vecSum", 32'(res_sum), 32'(v.expSum));
            checkOutput("vecCout", 32'(res_cout), 32'(v.expCout));
            checkOutput("vecId", 32'(res_id), 32'(v.expId));
            nextCycle();
            checkOutput("vecValidDrop", 32'(res_valid), 32'd0);
            checkOutput("vecIdleBusy", 32'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 8'h3C, 8'h0F, 1'b0, 8'h00, 8'h00, 8'h4B, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 8'h46, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 8'hCE, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 8'hAA, 8'hAA, 1'b1, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1};

      a_x = '0; a_y = '0; b_x = '0; b_y = '0;
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
      nextCycle();
      checkOutput("rstValid", 32'(res_valid), 32'd0);
      checkOutput("rstSum", 32'(res_sum), 32'd0);
      checkOutput("rstCout", 32'(res_cout), 32'd0);
      checkOutput("rstId", 32'(res_id), 32'd0);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstReady", 32'({a_ready, b_ready}), 32'd0);
      rst = 1'b0;
      nextCycle();

      $display("[TB] directed vector table");
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      $display("[TB] continuous contention, alternating grants");
      doReset();
      a_valid = 1'b1; a_x = 8'h11; a_y = 8'h22;
      b_valid = 1'b1; b_x = 8'hF0; b_y = 8'h20;
      res_ready = 1'b1;
      prevCyc = 0;
      for (int op = 0; op < 4; op++) begin
         waitAccept(seenA, seenB, ok);
         if (!ok) break;
         checkOutput("rrGrantA", 32'(seenA), 32'((op % 2) == 0));
         checkOutput("rrGrantB", 32'(seenB), 32'((op % 2) == 1));
         if (op > 0) checkOutput("rrInterval", 32'(cyc - prevCyc), 32'(WIDTH + 2));
         prevCyc = cyc;
         nextCycle();
         waitResult(lat, ok);
         if (!ok) break;
         checkOutput("rrSum", 32'(res_sum), (op % 2) ? 32'h10 : 32'h33);
         checkOutput("rrCout", 32'(res_cout), (op % 2) ? 32'd1 : 32'd0);
         checkOutput("rrId", 32'(res_id), 32'(op % 2));
      end

      $display("[TB] result backpressure");
      nextCycle();
      res_ready = 1'b0;
      waitAccept(seenA, seenB, ok);
      checkOutput("bpGrantA", 32'(seenA), 32'd1);
      nextCycle();
      waitResult(lat, ok);
      for (int k = 0; k < 5; k++) begin
         nextCycle();
         checkOutput("bpValidHeld", 32'(res_valid), 32'd1);
         checkOutput("bpSumHeld", 32'(res_sum), 32'h33);
         checkOutput("bpCoutHeld", 32'(res_cout), 32'd0);
         checkOutput("bpIdHeld", 32'(res_id), 32'd0);
         checkOutput("bpReadyLow", 32'({a_ready, b_ready}), 32'd0);
      end
      res_ready = 1'b1;
      nextCycle();
      checkOutput("bpValidDrop", 32'(res_valid), 32'd0);
      #1;
      checkOutput("bpIdleGrantB", 32'({a_ready, b_ready}), 32'b01);
      nextCycle();
      checkOutput("bpNextBusy", 32'(busy), 32'd1);
      a_valid = 1'b0;
      b_valid = 1'b0;
      waitResult(lat, ok);
      checkOutput("bpNextSum", 32'(res_sum), 32'h10);
      checkOutput("bpNextId", 32'(res_id), 32'd1);
      nextCycle();

      $display("[TB] reset during RUN");
      a_valid = 1'b1; a_x = 8'h5A; a_y = 8'h33; res_ready = 1'b1;
      waitAccept(seenA, seenB, ok);
      checkOutput("midGrantA", 32'(seenA), 32'd1);
      nextCycle();
      a_valid = 1'b0;
      repeat (3) nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("midRstValid", 32'(res_valid), 32'd0);
      checkOutput("midRstSum", 32'(res_sum), 32'd0);
      checkOutput("midRstCout", 32'(res_cout), 32'd0);
      checkOutput("midRstId", 32'(res_id), 32'd0);
      checkOutput("midRstBusy", 32'(busy), 32'd0);
      nextCycle();
      rst = 1'b0;
      sawResult = 1'b0;
      repeat (15) begin
         nextCycle();
         if (res_valid) sawResult = 1'b1;
      end
      checkOutput("midNoResult", 32'(sawResult), 32'd0);
      applyStimulus('{1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1});

      $display("[TB] random stress with backpressure");
      doReset();
      modelLast = 1'b1;
      for (int op = 0; op < 200; op++) begin
         sel = 2'($urandom_range(1, 3));
         a_valid = sel[0]; a_x = 8'($urandom); a_y = 8'($urandom);
         b_valid = sel[1]; b_x = 8'($urandom); b_y = 8'($urandom);
         expId = (sel[0] && sel[1]) ? !modelLast : sel[1];
         full  = expId ? ({1'b0, b_x} + {1'b0, b_y}) : ({1'b0, a_x} + {1'b0, a_y});
         waitAccept(seenA, seenB, ok);
         if (!ok) break;
         checkOutput("rndGrantB", 32'(seenB), 32'(expId));
         checkOutput("rndGrantA", 32'(seenA), 32'(!expId));
         modelLast = expId;
         nextCycle();
         a_valid = 1'b0; b_valid = 1'b0;
         a_x = 8'($urandom); b_y = 8'($urandom);
         ok = 1'b0;
         for (int k = 0; k < 100; k++) begin
            nextCycle();
            if (res_valid) begin
               checkOutput("rndSum", 32'(res_sum), 32'(full[WIDTH-1:0]));
               checkOutput("rndCout", 32'(res_cout), 32'(full[WIDTH]));
               checkOutput("rndId", 32'(res_id), 32'(expId));
               res_ready = 1'($urandom_range(0, 1));
               if (res_ready) begin
                  ok = 1'b1;
                  break;
               end
            end else begin
               res_ready = 1'($urandom_range(0, 1));
            end
         end
         if (!ok) begin
            reportTimeout("rndHandshake");
            break;
         end
         nextCycle();
         checkOutput("rndValidDrop", 32'(res_valid), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
